// File: rtl/iic_defs.sv
// iic_defs: shared state encoding and address-byte layout for the I2C target.
package iic_defs;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  localparam int RW_BIT = 0;
endpackage

// File: rtl/iic_filt.sv
// iic_filt: 2-flop synchronizer plus a FILT-sample glitch filter with one-cycle edge pulses.
module iic_filt #(
  parameter int FILT = 3
) (
  input  logic bus_clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic [3:0] cnt;
  logic flip;
  assign flip = (sync[1] != level) && (cnt == 4'(FILT - 1));
  always_ff @(posedge bus_clk)
    if (reset) begin
      sync  <= 2'b11;
      cnt   <= 4'd0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], pin};
      cnt   <= (sync[1] == level || flip) ? 4'd0 : cnt + 4'd1;
      level <= flip ? sync[1] : level;
      rise  <= flip & sync[1];
      fall  <= flip & ~sync[1];
    end
endmodule

// File: rtl/iic_slave.sv
// iic_slave: I2C target exposing an 8-bit-addressed register port with an auto-incrementing pointer.
module iic_slave
  import iic_defs::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         FILT     = 3
) (
  input  logic       bus_clk,
  input  logic       reset,
  input  logic       scl_pin,
  inout  wire        sda_pin,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);
  state_t state, state_d;
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, byte_done, match, rd, sda_lo, sda_d, we_n, re_n, we_q, re_q;
  logic [3:0] cnt;
  logic [7:0] sh;
  logic [2:0] bidx;

  iic_filt #(.FILT(FILT)) u_scl (.bus_clk(bus_clk), .reset(reset), .pin(scl_pin),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  iic_filt #(.FILT(FILT)) u_sda (.bus_clk(bus_clk), .reset(reset), .pin(sda_pin),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  // An SDA change coinciding with an SCL edge is a data edge, never START/STOP.
  assign start     = sda_fall & scl_lvl & ~scl_rise;
  assign stop      = sda_rise & scl_lvl & ~scl_rise;
  assign byte_done = cnt[3];
  assign match     = sh[7:1] == DEV_ADDR;
  assign bidx      = ~cnt[2:0];
  assign sda_pin   = (sda_lo && !reset) ? 1'b0 : 1'bz;

  always_ff @(posedge bus_clk)
    if (reset) state <= IDLE;
    else       state <= state_d;

  always_comb begin
    state_d = state;
    sda_d   = sda_lo;
    we_n    = 1'b0;
    re_n    = 1'b0;
    if (start) begin
      state_d = ADDR;
      sda_d   = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      sda_d   = 1'b0;
    end else if (scl_rise) begin
      state_d = (state == RDATA_ACK && sda_lvl) ? IGNORE : state;
    end else if (scl_fall) begin
      case (state)
        ADDR: if (byte_done) begin
          state_d = match ? ADDR_ACK : IGNORE;
          sda_d   = match;
          re_n    = match & sh[RW_BIT];
        end
        ADDR_ACK: begin
          state_d = rd ? RDATA : PTR;
          sda_d   = rd & ~sh[7];
        end
        PTR: if (byte_done) begin
          state_d = PTR_ACK;
          sda_d   = 1'b1;
        end
        PTR_ACK, WDATA_ACK: begin
          state_d = WDATA;
          sda_d   = 1'b0;
        end
        WDATA: if (byte_done) begin
          state_d = WDATA_ACK;
          sda_d   = 1'b1;
          we_n    = 1'b1;
        end
        RDATA: begin
          state_d = byte_done ? RDATA_ACK : RDATA;
          sda_d   = ~byte_done & ~sh[bidx];
          re_n    = byte_done;
        end
        RDATA_ACK: begin
          state_d = RDATA;
          sda_d   = ~sh[7];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge bus_clk)
    if (reset) begin
      sda_lo    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      cnt       <= 4'd0;
      sh        <= 8'h00;
      rd        <= 1'b0;
    end else begin
      sda_lo <= sda_d;
      reg_we <= we_n;
      reg_re <= re_n;
      we_q   <= reg_we;
      re_q   <= reg_re;
      if (we_n) reg_wdata <= sh;
      if (start || (scl_fall && state_d != state)) cnt <= 4'd0;
      else if (scl_rise && !byte_done)              cnt <= cnt + 4'd1;
      if (scl_rise && !byte_done && (state == ADDR || state == PTR || state == WDATA))
        sh <= {sh[6:0], sda_lvl};
      if (re_q) sh <= reg_rdata;
      if (state == ADDR && state_d == ADDR_ACK) rd <= sh[RW_BIT];
      // Pointer advances only after the strobe and its following cycle have seen it.
      if (state == PTR && state_d == PTR_ACK) reg_addr <= sh;
      else if (we_q || re_q)                   reg_addr <= reg_addr + 8'd1;
    end
endmodule

// File: tb/tb_iic_slave.sv
// tb_iic_slave: bit-banged I2C master against iic_slave with a register-file environment and a transaction-level model.
module tb_iic_slave;
  localparam int Q = 12;

  logic bus_clk = 1'b0;
  logic reset = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic glitch = 1'b0;
  wire  sda;
  logic [7:0] reg_addr, reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic reg_we, reg_re;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  iic_slave #(.DEV_ADDR(7'h50), .FILT(3)) dut (
    .bus_clk(bus_clk), .reset(reset), .scl_pin(m_scl), .sda_pin(sda),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata));

  always #5 bus_clk = ~bus_clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rf [256];
  logic [7:0] ref_mem [256];
  logic rf_ok = 1'b0;
  logic [15:0] we_log [$];
  logic [7:0] re_log [$];
  int drv_cnt = 0;
  logic both_hi = 1'b0, addr_moved = 1'b0, strb_prev = 1'b0;
  logic [7:0] addr_prev = 8'h00;

  // Register file seen by the target: read data returned the cycle after reg_re.
  always @(posedge bus_clk) begin
    if (!rf_ok) begin
      for (int i = 0; i < 256; i++) rf[i] <= 8'(i + 1);
      rf_ok <= 1'b1;
    end
    if (reg_re) reg_rdata <= rf[reg_addr];
    if (reg_we) rf[reg_addr] <= reg_wdata;
  end

  always @(negedge bus_clk) begin
    if (reg_we) we_log.push_back({reg_addr, reg_wdata});
    if (reg_re) re_log.push_back(reg_addr);
    if (m_sda && sda === 1'b0) drv_cnt <= drv_cnt + 1;
    if (reg_we && reg_re) both_hi <= 1'b1;
    if (strb_prev && reg_addr !== addr_prev) addr_moved <= 1'b1;
    strb_prev <= reg_we | reg_re;
    addr_prev <= reg_addr;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic wait_c(input int n);
    repeat (n) @(negedge bus_clk);
  endtask

  task automatic bit_x(input logic b, output logic s);
    m_sda = b; wait_c(Q);
    m_scl = 1'b1; wait_c(Q);
    s = sda;
    if (glitch) begin
      m_sda = ~b; wait_c(1); m_sda = b; wait_c(Q - 1);
    end else wait_c(Q);
    m_scl = 1'b0; wait_c(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_c(Q);
    m_scl = 1'b1; wait_c(Q);
    m_sda = 1'b0; wait_c(Q);
    m_scl = 1'b0; wait_c(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_c(Q);
    m_scl = 1'b1; wait_c(Q);
    m_sda = 1'b1; wait_c(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(d[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(1'b1, d[i]);
    bit_x(nack, s);
  endtask

  task automatic write_txn(input logic [6:0] dev, input logic [7:0] p, input logic [23:0] data,
                           input int n, input logic gl, output int acks);
    logic a;
    acks = 0;
    i2c_start();
    wr_byte({dev, 1'b0}, a); acks += int'(a);
    wr_byte(p, a);           acks += int'(a);
    for (int k = 0; k < n; k++) begin
      glitch = gl;
      wr_byte(data[23 - 8*k -: 8], a);
      glitch = 1'b0;
      acks += int'(a);
    end
    i2c_stop();
  endtask

  // Expected writes for a successful transaction land at consecutive, wrapping addresses.
  task automatic chk_writes(input string tag, input int w0, input logic [7:0] p,
                            input logic [23:0] data, input int n);
    chk({tag, "_we_cnt"}, 32'(we_log.size() - w0), 32'(n));
    for (int k = 0; k < n && w0 + k < we_log.size(); k++) begin
      chk({tag, "_we_addr"}, 32'(we_log[w0 + k][15:8]), 32'(8'(p + 8'(k))));
      chk({tag, "_we_data"}, 32'(we_log[w0 + k][7:0]), 32'(data[23 - 8*k -: 8]));
      ref_mem[8'(p + 8'(k))] = data[23 - 8*k -: 8];
    end
  endtask

  task automatic read_txn(input string tag, input logic [7:0] p, input int n);
    logic a;
    logic [7:0] d;
    int r0;
    r0 = re_log.size();
    i2c_start();
    wr_byte({7'h50, 1'b0}, a); chk({tag, "_ack_w"}, 32'(a), 32'd1);
    wr_byte(p, a);             chk({tag, "_ack_p"}, 32'(a), 32'd1);
    i2c_start();
    wr_byte({7'h50, 1'b1}, a); chk({tag, "_ack_r"}, 32'(a), 32'd1);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, d);
      chk({tag, "_rdata"}, 32'(d), 32'(ref_mem[8'(p + 8'(k))]));
    end
    i2c_stop();
    wait_c(4);
    // Every ACK slot opened by the target prefetches, including the one the master NACKs.
    chk({tag, "_re_cnt"}, 32'(re_log.size() - r0), 32'(n + 1));
    for (int k = 0; k <= n && r0 + k < re_log.size(); k++)
      chk({tag, "_re_addr"}, 32'(re_log[r0 + k]), 32'(8'(p + 8'(k))));
    chk({tag, "_ptr"}, 32'(reg_addr), 32'(8'(p + 8'(n + 1))));
  endtask

  typedef struct {
    logic [6:0]  dev;
    logic [7:0]  ptr;
    logic [23:0] data;
    int          n;
    int          acks;
    logic [7:0]  ptr_end;
  } vec_t;

  initial begin
    vec_t vt [4];
    int w0, r0, d0, acks, n;
    logic a;
    logic s;
    logic [7:0] p;
    logic [23:0] data;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i + 1);
    wait_c(4);
    chk("rst_addr", 32'(reg_addr), 32'h00);
    chk("rst_wdata", 32'(reg_wdata), 32'h00);
    chk("rst_we", 32'(reg_we), 32'd0);
    chk("rst_re", 32'(reg_re), 32'd0);
    chk("rst_sda", 32'(sda), 32'd1);
    reset = 1'b0;
    wait_c(4);

    vt[0] = '{7'h50, 8'h10, 24'hA53C00, 2, 4, 8'h12};
    vt[1] = '{7'h50, 8'hFF, 24'h112200, 2, 4, 8'h01};
    vt[2] = '{7'h51, 8'h30, 24'h556600, 2, 0, 8'h01};
    vt[3] = '{7'h50, 8'h80, 24'h770000, 1, 3, 8'h81};
    for (int v = 0; v < 4; v++) begin
      w0 = we_log.size();
      d0 = drv_cnt;
      write_txn(vt[v].dev, vt[v].ptr, vt[v].data, vt[v].n, 1'b0, acks);
      wait_c(4);
      chk("vec_acks", 32'(acks), 32'(vt[v].acks));
      chk_writes("vec", w0, vt[v].ptr, vt[v].data, vt[v].acks == 0 ? 0 : vt[v].n);
      chk("vec_ptr", 32'(reg_addr), 32'(vt[v].ptr_end));
      if (vt[v].acks == 0) chk("vec_nodrive", 32'(drv_cnt - d0), 32'd0);
    end

    read_txn("comb", 8'h20, 3);

    w0 = we_log.size();
    write_txn(7'h50, 8'h60, 24'hF7A500, 2, 1'b1, acks);
    wait_c(4);
    chk("glitch_acks", 32'(acks), 32'd4);
    chk_writes("glitch", w0, 8'h60, 24'hF7A500, 2);

    i2c_start();
    wr_byte({7'h50, 1'b0}, a); chk("rst_ack_w", 32'(a), 32'd1);
    wr_byte(8'h40, a);         chk("rst_ack_p", 32'(a), 32'd1);
    i2c_start();
    wr_byte({7'h50, 1'b1}, a); chk("rst_ack_r", 32'(a), 32'd1);
    chk("rst_msb_low", 32'(sda), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_release", 32'(sda), 32'd1);
    wait_c(1);
    chk("rst_mid_addr", 32'(reg_addr), 32'h00);
    reset = 1'b0;
    w0 = we_log.size();
    r0 = re_log.size();
    d0 = drv_cnt;
    for (int i = 0; i < 9; i++) begin
      bit_x(1'b1, s);
      chk("rst_bus_free", 32'(s), 32'd1);
    end
    i2c_stop();
    wait_c(4);
    chk("rst_no_we", 32'(we_log.size() - w0), 32'd0);
    chk("rst_no_re", 32'(re_log.size() - r0), 32'd0);
    chk("rst_no_drive", 32'(drv_cnt - d0), 32'd0);
    chk("rst_ptr", 32'(reg_addr), 32'h00);

    for (int t = 0; t < 12; t++) begin
      p = 8'($urandom_range(0, 255));
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        data = 24'($urandom);
        w0 = we_log.size();
        write_txn(7'h50, p, data, n, 1'b0, acks);
        wait_c(4);
        chk("rnd_acks", 32'(acks), 32'(n + 2));
        chk_writes("rnd", w0, p, data, n);
        chk("rnd_wptr", 32'(reg_addr), 32'(8'(p + 8'(n))));
      end else read_txn("rnd", p, n);
    end

    chk("strobe_overlap", 32'(both_hi), 32'd0);
    chk("addr_stable", 32'(addr_moved), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
